// File: rtl/io_bus_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_bus_sequencer_pkg : state encoding, default timing, counter width helper
// Revision 1.0
// ---------------------------------------------------------------------------
package io_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  localparam int C_DEF_SETUP_CYCLES   = 1;
  localparam int C_DEF_STROBE_CYCLES  = 2;
  localparam int C_DEF_TIMEOUT_CYCLES = 255;

  // One bit of headroom over the largest phase length so a load never wraps.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_bus_sequencer_if : control-unit request / interface-stage strobe bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface io_bus_sequencer_if;

  logic req_rd;
  logic req_wr;
  logic io_wait;
  logic address_ld_n;
  logic data_ld_n;
  logic rd;
  logic wr;
  logic data_dir_out;
  logic data_dir_in;
  logic rd_capture;
  logic busy;
  logic done;
  logic timeout_err;

  modport master (
    output req_rd, req_wr, io_wait,
    input  address_ld_n, data_ld_n, rd, wr, data_dir_out, data_dir_in,
           rd_capture, busy, done, timeout_err
  );

  modport slave (
    input  req_rd, req_wr, io_wait,
    output address_ld_n, data_ld_n, rd, wr, data_dir_out, data_dir_in,
           rd_capture, busy, done, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/io_bus_sequencer_cycle_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_bus_sequencer_cycle_counter : loadable down-counter with zero flag
// Revision 1.0
// ---------------------------------------------------------------------------
module io_bus_sequencer_cycle_counter #(
  parameter int WIDTH = 9
) (
  input  wire logic             clock,
  input  wire logic             notReset,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] value_i,
  input  wire logic             dec_i,
  output logic                  zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!notReset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/io_bus_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_bus_sequencer : phases CPU rd/wr requests into latch/direction/strobe
// controls with io_wait stretching and bounded timeout. Revision 1.0
// ---------------------------------------------------------------------------
module io_bus_sequencer
  import io_bus_sequencer_pkg::*;
#(
  parameter int SETUP_CYCLES   = C_DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = C_DEF_STROBE_CYCLES,
  parameter int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
  input wire logic          clock,
  input wire logic          notReset,
  io_bus_sequencer_if.slave bus
);

  localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_SETUP_LD   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_STROBE_LD  = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);

  state_e  state_q;
  logic    is_rd_q;
  logic    ext_q;
  logic    rd_q, wr_q, dir_out_q, dir_in_q, busy_q, done_q, tmo_err_q;

  logic          cnt_load_d;
  logic [CW-1:0] cnt_value_d;
  logic          cnt_dec_d;
  logic          cnt_zero;
  logic          req_any;
  logic          strobe_exit;
  logic          timeout_hit;

  assign req_any = bus.req_rd || bus.req_wr;

  // Past the minimum strobe any io_wait=0 ends the phase; at zero with io_wait
  // still high the extension budget is spent.
  assign timeout_hit = (state_q == S_STROBE) && ext_q && cnt_zero && bus.io_wait;
  assign strobe_exit = (state_q == S_STROBE) &&
                       (ext_q ? (!bus.io_wait || cnt_zero) : (cnt_zero && !bus.io_wait));

  always_comb begin
    cnt_load_d  = 1'b0;
    cnt_value_d = '0;
    cnt_dec_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          cnt_load_d  = 1'b1;
          cnt_value_d = C_SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          cnt_load_d  = 1'b1;
          cnt_value_d = C_STROBE_LD;
        end else begin
          cnt_dec_d = 1'b1;
        end
      end
      S_STROBE: begin
        if (!ext_q && cnt_zero && bus.io_wait) begin
          cnt_load_d  = 1'b1;
          cnt_value_d = C_TIMEOUT_LD;
        end else begin
          cnt_dec_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  io_bus_sequencer_cycle_counter #(
    .WIDTH (CW)
  ) u_cycle_counter (
    .clock    (clock),
    .notReset (notReset),
    .load_i   (cnt_load_d),
    .value_i  (cnt_value_d),
    .dec_i    (cnt_dec_d),
    .zero_o   (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q   <= S_IDLE;
      is_rd_q   <= 1'b0;
      ext_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      dir_out_q <= 1'b0;
      dir_in_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_q   <= S_SETUP;
            is_rd_q   <= bus.req_rd;
            ext_q     <= 1'b0;
            busy_q    <= 1'b1;
            dir_out_q <= !bus.req_rd;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_q  <= S_STROBE;
            rd_q     <= is_rd_q;
            wr_q     <= !is_rd_q;
            dir_in_q <= is_rd_q;
          end
        end
        S_STROBE: begin
          if (strobe_exit) begin
            state_q   <= S_HOLD;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            dir_in_q  <= 1'b0;
            done_q    <= 1'b1;
            tmo_err_q <= timeout_hit;
          end else if (!ext_q && cnt_zero) begin
            ext_q <= 1'b1;
          end
        end
        S_HOLD: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          dir_out_q <= 1'b0;
          ext_q     <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Latch enables act on the acceptance edge itself, so they cannot be registered.
  assign bus.address_ld_n = !(notReset && (state_q == S_IDLE) && req_any);
  assign bus.data_ld_n    = !(notReset && (state_q == S_IDLE) && bus.req_wr && !bus.req_rd);
  // rd_capture depends on the io_wait sample of the exiting cycle.
  assign bus.rd_capture   = (state_q == S_STROBE) && is_rd_q && !bus.io_wait &&
                            (ext_q || cnt_zero);

  assign bus.rd           = rd_q;
  assign bus.wr           = wr_q;
  assign bus.data_dir_out = dir_out_q;
  assign bus.data_dir_in  = dir_in_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout_err  = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_io_bus_sequencer : cycle-vector bench, TIMEOUT_CYCLES=4, defaults otherwise
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_io_bus_sequencer;

  // {address_ld_n, data_ld_n, rd, wr, data_dir_out, data_dir_in, rd_capture, busy, done, timeout_err}
  localparam logic [9:0] E_IDLE     = 10'b11_0000_0000;
  localparam logic [9:0] E_ACC_RD   = 10'b01_0000_0000;
  localparam logic [9:0] E_ACC_WR   = 10'b00_0000_0000;
  localparam logic [9:0] E_SETUP_RD = 10'b11_0000_0100;
  localparam logic [9:0] E_SETUP_WR = 10'b11_0010_0100;
  localparam logic [9:0] E_STB_RD   = 10'b11_1001_0100;
  localparam logic [9:0] E_CAP_RD   = 10'b11_1001_1100;
  localparam logic [9:0] E_STB_WR   = 10'b11_0110_0100;
  localparam logic [9:0] E_HOLD_RD  = 10'b11_0000_0110;
  localparam logic [9:0] E_HOLD_WR  = 10'b11_0010_0110;
  localparam logic [9:0] E_HOLD_TO  = 10'b11_0000_0111;

  typedef struct {
    string      name;
    bit         chk;
    bit         rst_n;
    bit         rd;
    bit         wr;
    bit         wt;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  vec_t vecs[$];
  sb_t  sb[$];

  io_bus_sequencer_if bus ();

  io_bus_sequencer #(
    .SETUP_CYCLES   (1),
    .STROBE_CYCLES  (2),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clock    (clk),
    .notReset (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input bit chk, input bit r, input bit a,
                     input bit b, input bit w, input logic [9:0] e);
    vec_t v;
    v.name = n; v.chk = chk; v.rst_n = r; v.rd = a; v.wr = b; v.wt = w; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    sb_t        s;
    logic [9:0] act;
    @(posedge clk);
    #1;
    rst_n       = v.rst_n;
    bus.req_rd  = v.rd;
    bus.req_wr  = v.wr;
    bus.io_wait = v.wt;
    if (v.chk) begin
      s.name = v.name;
      s.exp  = v.exp;
      sb.push_back(s);
    end
    @(negedge clk);
    act = {bus.address_ld_n, bus.data_ld_n, bus.rd, bus.wr, bus.data_dir_out,
           bus.data_dir_in, bus.rd_capture, bus.busy, bus.done, bus.timeout_err};
    if (v.chk) begin
      s = sb.pop_front();
      n_cmp++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: outputs got %b want %b", s.name, act, s.exp);
      end
    end
    if (v.rst_n) begin
      n_cmp++;
      if ((bus.rd && bus.wr) || (bus.data_dir_in && bus.data_dir_out)) begin
        n_fail++;
        $display("FAIL %s exclusivity: rd/wr/dir_in/dir_out got %b%b%b%b want no overlap",
                 v.name, bus.rd, bus.wr, bus.data_dir_in, bus.data_dir_out);
      end
    end
  endtask

  task automatic step(input string n, input bit r, input bit a, input bit b,
                      input bit w, input logic [9:0] e);
    vec_t v;
    v.name = n; v.chk = 1'b1; v.rst_n = r; v.rd = a; v.wr = b; v.wt = w; v.exp = e;
    apply(v);
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.req_rd  = 1'b0;
    bus.req_wr  = 1'b0;
    bus.io_wait = 1'b0;

    // reset, with a request held during reset that must not reach the latches
    add("rst0", 0, 0, 0, 0, 0, E_IDLE);
    add("rst1", 1, 0, 1, 1, 0, E_IDLE);
    add("idle", 1, 1, 0, 0, 0, E_IDLE);
    // read, no wait
    add("rd.c0", 1, 1, 1, 0, 0, E_ACC_RD);
    add("rd.c1", 1, 1, 0, 0, 0, E_SETUP_RD);
    add("rd.c2", 1, 1, 0, 0, 0, E_STB_RD);
    add("rd.c3", 1, 1, 0, 0, 0, E_CAP_RD);
    add("rd.c4", 1, 1, 0, 0, 0, E_HOLD_RD);
    add("rd.c5", 1, 1, 0, 0, 0, E_IDLE);
    // write, io_wait cycles 3-5
    add("wr.c0", 1, 1, 0, 1, 0, E_ACC_WR);
    add("wr.c1", 1, 1, 0, 0, 0, E_SETUP_WR);
    add("wr.c2", 1, 1, 0, 0, 0, E_STB_WR);
    add("wr.c3", 1, 1, 0, 0, 1, E_STB_WR);
    add("wr.c4", 1, 1, 0, 0, 1, E_STB_WR);
    add("wr.c5", 1, 1, 0, 0, 1, E_STB_WR);
    add("wr.c6", 1, 1, 0, 0, 0, E_STB_WR);
    add("wr.c7", 1, 1, 0, 0, 0, E_HOLD_WR);
    add("wr.c8", 1, 1, 0, 0, 0, E_IDLE);
    // read, io_wait stuck: timeout after 4 extra cycles
    add("to.c0", 1, 1, 1, 0, 1, E_ACC_RD);
    add("to.c1", 1, 1, 0, 0, 1, E_SETUP_RD);
    for (int i = 2; i <= 7; i++) add($sformatf("to.c%0d", i), 1, 1, 0, 0, 1, E_STB_RD);
    add("to.c8", 1, 1, 0, 0, 1, E_HOLD_TO);
    add("to.c9", 1, 1, 0, 0, 0, E_IDLE);
    // read, io_wait drops in the 4th extra cycle: normal exit with capture
    add("bd.c0", 1, 1, 1, 0, 0, E_ACC_RD);
    add("bd.c1", 1, 1, 0, 0, 0, E_SETUP_RD);
    add("bd.c2", 1, 1, 0, 0, 0, E_STB_RD);
    for (int i = 3; i <= 6; i++) add($sformatf("bd.c%0d", i), 1, 1, 0, 0, 1, E_STB_RD);
    add("bd.c7", 1, 1, 0, 0, 0, E_CAP_RD);
    add("bd.c8", 1, 1, 0, 0, 0, E_HOLD_RD);
    add("bd.c9", 1, 1, 0, 0, 0, E_IDLE);
    // io_wait only before the last counted cycle and after it: no effect
    add("lw.c0", 1, 1, 1, 0, 0, E_ACC_RD);
    add("lw.c1", 1, 1, 0, 0, 0, E_SETUP_RD);
    add("lw.c2", 1, 1, 0, 0, 1, E_STB_RD);
    add("lw.c3", 1, 1, 0, 0, 0, E_CAP_RD);
    add("lw.c4", 1, 1, 0, 0, 1, E_HOLD_RD);
    add("lw.c5", 1, 1, 0, 0, 0, E_IDLE);

    foreach (vecs[i]) apply(vecs[i]);

    // both requests: read wins; write during STROBE/HOLD ignored; back-to-back accept
    step("both.c0", 1, 1, 1, 0, E_ACC_RD);
    step("both.c1", 1, 0, 0, 0, E_SETUP_RD);
    step("both.c2", 1, 0, 1, 0, E_STB_RD);
    step("both.c3", 1, 0, 1, 0, E_CAP_RD);
    step("both.c4", 1, 0, 1, 0, E_HOLD_RD);
    step("b2b.c5",  1, 0, 1, 0, E_ACC_WR);
    step("b2b.c6",  1, 0, 0, 0, E_SETUP_WR);
    step("b2b.c7",  1, 0, 0, 0, E_STB_WR);
    step("b2b.c8",  1, 0, 0, 0, E_STB_WR);
    step("b2b.c9",  1, 0, 0, 0, E_HOLD_WR);
    step("b2b.c10", 1, 0, 0, 0, E_IDLE);

    // reset in cycle 2 of a write, then a read accepted right after release
    step("mr.c0", 1, 0, 1, 0, E_ACC_WR);
    step("mr.c1", 1, 0, 0, 0, E_SETUP_WR);
    step("mr.c2", 0, 0, 0, 0, E_STB_WR);
    step("mr.c3", 1, 1, 0, 0, E_ACC_RD);
    step("mr.c4", 1, 0, 0, 0, E_SETUP_RD);
    step("mr.c5", 1, 0, 0, 0, E_STB_RD);
    step("mr.c6", 1, 0, 0, 0, E_CAP_RD);
    step("mr.c7", 1, 0, 0, 0, E_HOLD_RD);
    step("mr.c8", 1, 0, 0, 0, E_IDLE);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: leftover entries got %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
